local_mem_axi_arb2: RTL and testbench

Two-requester AXI-MM arbiter that shares one PIM-mapped local memory bank (the `local_mem_to_afu[n]` side, already clock-crossed to the AFU clock) between two AFU engines. Read and write address channels are arbitrated independently and round-robin. The W channel is locked to the current AW winner for a full burst. Requester identity is carried in the ID MSB so B/R responses route back without a lookup table. Per-requester outstanding-read limits stop one engine from monopolising the bank.

---
 rtl/local_mem_axi_arb2.sv | 225 ++++++++++++++++++++++
 tb/tb_local_mem_axi_arb2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/local_mem_axi_arb2.sv
// Two-requester AXI-MM arbiter in front of one local memory bank.
// Independent round-robin AR/AW arbitration, W locked to the AW winner, requester tagged in the ID MSB.
module local_mem_axi_arb2 #(
   parameter int ADDR_W       = 34,
   parameter int DATA_W       = 512,
   parameter int ID_W         = 8,
   parameter int LEN_W        = 8,
   parameter int MAX_RD_OUTST = 32
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                s0_awvalid,
   output logic                s0_awready,
   input  logic [ID_W-1:0]     s0_awid,
   input  logic [ADDR_W-1:0]   s0_awaddr,
   input  logic [LEN_W-1:0]    s0_awlen,
   input  logic                s0_wvalid,
   output logic                s0_wready,
   input  logic [DATA_W-1:0]   s0_wdata,
   input  logic [DATA_W/8-1:0] s0_wstrb,
   input  logic                s0_wlast,
   output logic                s0_bvalid,
   input  logic                s0_bready,
   output logic [ID_W-1:0]     s0_bid,
   input  logic                s0_arvalid,
   output logic                s0_arready,
   input  logic [ID_W-1:0]     s0_arid,
   input  logic [ADDR_W-1:0]   s0_araddr,
   input  logic [LEN_W-1:0]    s0_arlen,
   output logic                s0_rvalid,
   input  logic                s0_rready,
   output logic [ID_W-1:0]     s0_rid,
   output logic [DATA_W-1:0]   s0_rdata,
   output logic                s0_rlast,

   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [ID_W-1:0]     s1_awid,
   input  logic [ADDR_W-1:0]   s1_awaddr,
   input  logic [LEN_W-1:0]    s1_awlen,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   input  logic [DATA_W-1:0]   s1_wdata,
   input  logic [DATA_W/8-1:0] s1_wstrb,
   input  logic                s1_wlast,
   output logic                s1_bvalid,
   input  logic                s1_bready,
   output logic [ID_W-1:0]     s1_bid,
   input  logic                s1_arvalid,
   output logic                s1_arready,
   input  logic [ID_W-1:0]     s1_arid,
   input  logic [ADDR_W-1:0]   s1_araddr,
   input  logic [LEN_W-1:0]    s1_arlen,
   output logic                s1_rvalid,
   input  logic                s1_rready,
   output logic [ID_W-1:0]     s1_rid,
   output logic [DATA_W-1:0]   s1_rdata,
   output logic                s1_rlast,

   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [ID_W:0]       m_awid,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [LEN_W-1:0]    m_awlen,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [ID_W:0]       m_bid,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ID_W:0]       m_arid,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [LEN_W-1:0]    m_arlen,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [ID_W:0]       m_rid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_rlast
);

   // state   | meaning
   // W_IDLE  | AW arbitration open, no W beats passed
   // W_BURST | AW blocked, W of w_owner passed through until wlast

   localparam int CNT_W = $clog2(MAX_RD_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RD_OUTST);

   typedef enum logic {W_IDLE, W_BURST} w_state_t;

   w_state_t         w_state;
   logic             w_owner;
   logic             wr_last;
   logic             aw_lock;
   logic             aw_lock_sel;
   logic             rd_last;
   logic             ar_lock;
   logic             ar_lock_sel;
   logic [CNT_W-1:0] rd_cnt0;
   logic [CNT_W-1:0] rd_cnt1;

   logic ar_elig0, ar_elig1, ar_sel, ar_any;
   logic aw_sel, aw_any, w_act;
   logic ar_hs0, ar_hs1, r_done0, r_done1;

   // A stalled grant is pinned so a late-arriving peer cannot steal a pending valid.
   always_comb begin
      ar_elig0 = s0_arvalid && (rd_cnt0 < CNT_MAX);
      ar_elig1 = s1_arvalid && (rd_cnt1 < CNT_MAX);
      if (ar_lock)
         ar_sel = ar_lock_sel;
      else if (ar_elig0 && ar_elig1)
         ar_sel = ~rd_last;
      else
         ar_sel = ar_elig1;
      ar_any = rst_n && (ar_sel ? ar_elig1 : ar_elig0);

      if (aw_lock)
         aw_sel = aw_lock_sel;
      else if (s0_awvalid && s1_awvalid)
         aw_sel = ~wr_last;
      else
         aw_sel = s1_awvalid;
      aw_any = rst_n && (w_state == W_IDLE) && (aw_sel ? s1_awvalid : s0_awvalid);
      w_act  = rst_n && (w_state == W_BURST);
   end

   assign m_arvalid  = ar_any;
   assign m_arid     = {ar_sel, ar_sel ? s1_arid : s0_arid};
   assign m_araddr   = ar_sel ? s1_araddr : s0_araddr;
   assign m_arlen    = ar_sel ? s1_arlen : s0_arlen;
   assign s0_arready = ar_any && !ar_sel && m_arready;
   assign s1_arready = ar_any && ar_sel && m_arready;

   assign m_awvalid  = aw_any;
   assign m_awid     = {aw_sel, aw_sel ? s1_awid : s0_awid};
   assign m_awaddr   = aw_sel ? s1_awaddr : s0_awaddr;
   assign m_awlen    = aw_sel ? s1_awlen : s0_awlen;
   assign s0_awready = aw_any && !aw_sel && m_awready;
   assign s1_awready = aw_any && aw_sel && m_awready;

   assign m_wvalid   = w_act && (w_owner ? s1_wvalid : s0_wvalid);
   assign m_wdata    = w_owner ? s1_wdata : s0_wdata;
   assign m_wstrb    = w_owner ? s1_wstrb : s0_wstrb;
   assign m_wlast    = w_owner ? s1_wlast : s0_wlast;
   assign s0_wready  = w_act && !w_owner && m_wready;
   assign s1_wready  = w_act && w_owner && m_wready;

   assign s0_bvalid  = m_bvalid && !m_bid[ID_W];
   assign s1_bvalid  = m_bvalid && m_bid[ID_W];
   assign s0_bid     = m_bid[ID_W-1:0];
   assign s1_bid     = m_bid[ID_W-1:0];
   assign m_bready   = m_bid[ID_W] ? s1_bready : s0_bready;

   assign s0_rvalid  = m_rvalid && !m_rid[ID_W];
   assign s1_rvalid  = m_rvalid && m_rid[ID_W];
   assign s0_rid     = m_rid[ID_W-1:0];
   assign s1_rid     = m_rid[ID_W-1:0];
   assign s0_rdata   = m_rdata;
   assign s1_rdata   = m_rdata;
   assign s0_rlast   = m_rlast;
   assign s1_rlast   = m_rlast;
   assign m_rready   = m_rid[ID_W] ? s1_rready : s0_rready;

   assign ar_hs0  = m_arvalid && m_arready && !ar_sel;
   assign ar_hs1  = m_arvalid && m_arready && ar_sel;
   assign r_done0 = m_rvalid && m_rready && m_rlast && !m_rid[ID_W];
   assign r_done1 = m_rvalid && m_rready && m_rlast && m_rid[ID_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_last     <= 1'b1;
         ar_lock     <= 1'b0;
         ar_lock_sel <= 1'b0;
         rd_cnt0     <= '0;
         rd_cnt1     <= '0;
      end else begin
         ar_lock     <= m_arvalid && !m_arready;
         ar_lock_sel <= ar_sel;
         if (m_arvalid && m_arready)
            rd_last <= ar_sel;
         if (ar_hs0 && !r_done0)
            rd_cnt0 <= rd_cnt0 + CNT_W'(1);
         else if (r_done0 && !ar_hs0)
            rd_cnt0 <= rd_cnt0 - CNT_W'(1);
         if (ar_hs1 && !r_done1)
            rd_cnt1 <= rd_cnt1 + CNT_W'(1);
         else if (r_done1 && !ar_hs1)
            rd_cnt1 <= rd_cnt1 - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state     <= W_IDLE;
         w_owner     <= 1'b0;
         wr_last     <= 1'b1;
         aw_lock     <= 1'b0;
         aw_lock_sel <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               aw_lock     <= m_awvalid && !m_awready;
               aw_lock_sel <= aw_sel;
               if (m_awvalid && m_awready) begin
                  w_owner <= aw_sel;
                  wr_last <= aw_sel;
                  w_state <= W_BURST;
               end
            end
            W_BURST: begin
               aw_lock <= 1'b0;
               if (m_wvalid && m_wready && m_wlast)
                  w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_local_mem_axi_arb2.sv
// Scoreboard bench for local_mem_axi_arb2: expected AR/AW/W transfers are queued
// when stimulus is driven and popped when the master side handshakes.
module tb_local_mem_axi_arb2;
   localparam int ADDR_W = 34, DATA_W = 512, ID_W = 8, LEN_W = 8, MAX_RD_OUTST = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_wlast, s0_bvalid, s0_bready;
   logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
   logic [ID_W-1:0] s0_awid, s0_bid, s0_arid, s0_rid;
   logic [ADDR_W-1:0] s0_awaddr, s0_araddr;
   logic [LEN_W-1:0] s0_awlen, s0_arlen;
   logic [DATA_W-1:0] s0_wdata, s0_rdata;
   logic [DATA_W/8-1:0] s0_wstrb;
   logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
   logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
   logic [ID_W-1:0] s1_awid, s1_bid, s1_arid, s1_rid;
   logic [ADDR_W-1:0] s1_awaddr, s1_araddr;
   logic [LEN_W-1:0] s1_awlen, s1_arlen;
   logic [DATA_W-1:0] s1_wdata, s1_rdata;
   logic [DATA_W/8-1:0] s1_wstrb;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [ID_W:0] m_awid, m_bid, m_arid, m_rid;
   logic [ADDR_W-1:0] m_awaddr, m_araddr;
   logic [LEN_W-1:0] m_awlen, m_arlen;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic [DATA_W/8-1:0] m_wstrb;

   local_mem_axi_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
                        .MAX_RD_OUTST(MAX_RD_OUTST)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
      .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
      .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bid(s0_bid),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
      .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
      .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
      .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bid(s1_bid),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast)
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [ID_W:0] ar_q[$];
   logic [ID_W:0] aw_q[$];
   logic [32:0]   w_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && m_arvalid && m_arready) begin
         if (ar_q.size() == 0) chk("ar_extra", m_arid, 0);
         else chk("ar_id", m_arid, ar_q.pop_front());
      end
      if (rst_n && m_awvalid && m_awready) begin
         if (aw_q.size() == 0) chk("aw_extra", m_awid, 0);
         else chk("aw_id", m_awid, aw_q.pop_front());
      end
      if (rst_n && m_wvalid && m_wready) begin
         if (w_q.size() == 0) chk("w_extra", {m_wlast, m_wdata[31:0]}, 0);
         else chk("w_beat", {m_wlast, m_wdata[31:0]}, w_q.pop_front());
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {s0_awvalid, s0_wvalid, s0_wlast, s0_bready, s0_arvalid, s0_rready} = '0;
      {s1_awvalid, s1_wvalid, s1_wlast, s1_bready, s1_arvalid, s1_rready} = '0;
      {s0_awid, s0_arid, s1_awid, s1_arid} = '0;
      s0_awaddr = 34'h100; s0_araddr = 34'h200; s1_awaddr = 34'h300; s1_araddr = 34'h400;
      {s0_awlen, s0_arlen, s1_awlen, s1_arlen} = '0;
      s0_wdata = '0; s1_wdata = '0; s0_wstrb = '1; s1_wstrb = '1;
      {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
      m_bid = '0; m_rid = '0; m_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
      next_cyc();
      rst_n = 1'b1;
   endtask

   int acc;

   initial begin
      // AR round robin alternation
      do_reset();
      s0_arid = 8'h10; s1_arid = 8'h20;
      s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
      for (int i = 0; i < 6; i++) begin
         ar_q.push_back((i % 2 == 0) ? {1'b0, 8'h10} : {1'b1, 8'h20});
         @(negedge clk);
         chk("ar_alt_s0rdy", s0_arready, (i % 2 == 0));
         next_cyc();
      end
      s0_arvalid = 0; s1_arvalid = 0;

      // outstanding read limit on requester 0
      do_reset();
      s0_arid = 8'h33; s0_arvalid = 1; m_arready = 1;
      for (int i = 0; i < MAX_RD_OUTST; i++) begin
         ar_q.push_back({1'b0, 8'h33});
         next_cyc();
      end
      @(negedge clk);
      chk("limit_s0rdy", s0_arready, 0);
      chk("limit_mvalid", m_arvalid, 0);
      next_cyc();
      s1_arid = 8'h44; s1_arvalid = 1;
      ar_q.push_back({1'b1, 8'h44});
      @(negedge clk);
      chk("limit_s1rdy", s1_arready, 1);
      chk("limit_s0rdy2", s0_arready, 0);
      next_cyc();
      s1_arvalid = 0;
      m_rvalid = 1; m_rid = {1'b0, 8'h11}; m_rlast = 1; s0_rready = 1; s1_rready = 0;
      @(negedge clk);
      chk("r_s0_valid", s0_rvalid, 1);
      chk("r_s0_rid", s0_rid, 8'h11);
      chk("r_s1_valid", s1_rvalid, 0);
      chk("r_mready", m_rready, 1);
      chk("r_same_cyc_s0rdy", s0_arready, 0);
      next_cyc();
      m_rvalid = 0; m_rlast = 0;
      ar_q.push_back({1'b0, 8'h33});
      @(negedge clk);
      chk("after_r_s0rdy", s0_arready, 1);
      next_cyc();
      s0_arvalid = 0;

      // coincident R-last and AR for requester 1 (count is 1 here)
      s1_arvalid = 1; s1_rready = 1;
      m_rvalid = 1; m_rid = {1'b1, 8'h55}; m_rlast = 1;
      ar_q.push_back({1'b1, 8'h44});
      @(negedge clk);
      chk("coinc_s1rdy", s1_arready, 1);
      chk("coinc_s1rid", s1_rid, 8'h55);
      next_cyc();
      m_rvalid = 0; m_rlast = 0;
      for (int i = 0; i < MAX_RD_OUTST - 1; i++) ar_q.push_back({1'b1, 8'h44});
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s1_arready) acc++;
         next_cyc();
      end
      chk("coinc_cnt_hold", acc, MAX_RD_OUTST - 1);
      s1_arvalid = 0;

      // W locking to AW winner
      do_reset();
      m_awready = 1; m_wready = 1;
      s0_awvalid = 1; s0_awid = 8'h01; s0_awlen = 8'd3;
      s1_awvalid = 1; s1_awid = 8'h02; s1_awlen = 8'd0;
      s0_wvalid = 1; s0_wdata = DATA_W'(32'hA0); s0_wlast = 0;
      s1_wvalid = 1; s1_wdata = DATA_W'(32'hB0); s1_wlast = 1;
      aw_q.push_back({1'b0, 8'h01});
      @(negedge clk);
      chk("aw_s0_first", s0_awready, 1);
      chk("w_early_held", s0_wready, 0);
      next_cyc();
      s0_awvalid = 0;
      for (int i = 0; i < 4; i++) begin
         s0_wdata = DATA_W'(32'hA0 + i);
         s0_wlast = (i == 3);
         w_q.push_back({(i == 3), 32'hA0 + 32'(i)});
         @(negedge clk);
         chk("burst_s1_wrdy", s1_wready, 0);
         chk("burst_aw_blk", {m_awvalid, s1_awready}, 2'b00);
         next_cyc();
      end
      s0_wvalid = 0; s0_wlast = 0;
      aw_q.push_back({1'b1, 8'h02});
      @(negedge clk);
      chk("aw_s1_after_last", s1_awready, 1);
      chk("aw_s1_wrdy_idle", s1_wready, 0);
      next_cyc();
      s1_awvalid = 0;
      w_q.push_back({1'b1, 32'hB0});
      @(negedge clk);
      chk("w_s1_owner", {s1_wready, s0_wready}, 2'b10);
      next_cyc();
      s1_wvalid = 0;

      // B routing and backpressure
      m_bvalid = 1; m_bid = {1'b1, 8'h5A}; s0_bready = 1; s1_bready = 0;
      @(negedge clk);
      chk("b_route", {s1_bvalid, s0_bvalid}, 2'b10);
      chk("b_bid", s1_bid, 8'h5A);
      chk("b_backpress", m_bready, 0);
      next_cyc();
      s1_bready = 1;
      @(negedge clk);
      chk("b_ready", m_bready, 1);
      next_cyc();
      m_bvalid = 0;

      // reset mid-burst
      do_reset();
      m_awready = 1; m_wready = 1;
      s0_awvalid = 1; s0_awid = 8'h01; s0_awlen = 8'd3;
      s1_awvalid = 1; s1_awid = 8'h02;
      aw_q.push_back({1'b0, 8'h01});
      next_cyc();
      s0_awvalid = 0;
      s0_wvalid = 1; s0_wdata = DATA_W'(32'hA0); s0_wlast = 0;
      w_q.push_back({1'b0, 32'hA0});
      next_cyc();
      s0_wdata = DATA_W'(32'hA1);
      s0_awvalid = 1; s0_arvalid = 1; m_arready = 1;
      rst_n = 0;
      #1;
      chk("rst_async_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1; s0_wvalid = 0; s0_arvalid = 0;
      aw_q.push_back({1'b0, 8'h01});
      @(negedge clk);
      chk("rst_idle_prio", {s1_awready, s0_awready}, 2'b01);
      next_cyc();
      s0_awvalid = 0; s1_awvalid = 0;

      chk("ar_q_drained", ar_q.size(), 0);
      chk("aw_q_drained", aw_q.size(), 0);
      chk("w_q_drained", w_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
